// File: rtl/spi_master_ctrl_if.sv
// Bundles the command, TX FIFO, RX FIFO and SPI pins of the SPI master engine.
// Ports: command (work/op/len/cs_sel/cpol/cpha/div -> busy/done), TX FIFO (tx_rdata/tx_empty -> tx_rd),
// RX FIFO (rx_full -> rx_wdata/rx_wr), SPI pins (miso -> sclk/mosi/scsn). master = engine side, slave = environment side.
interface spi_master_ctrl_if #(
  parameter int DATA  = 8,
  parameter int NCS   = 2,
  parameter int DIV_W = 8,
  parameter int LEN_W = 16
);
  localparam int CSW = (NCS > 1) ? $clog2(NCS) : 1;

  // command side
  logic             work;
  logic             op;
  logic [LEN_W-1:0] len;
  logic [CSW-1:0]   cs_sel;
  logic             cpol;
  logic             cpha;
  logic [DIV_W-1:0] div;
  logic             busy;
  logic             done;
  // TX FIFO read side
  logic [DATA-1:0]  tx_rdata;
  logic             tx_rd;
  logic             tx_empty;
  // RX FIFO write side
  logic [DATA-1:0]  rx_wdata;
  logic             rx_wr;
  logic             rx_full;
  // SPI pins
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic [NCS-1:0]   scsn;

  modport master (
    input  work, op, len, cs_sel, cpol, cpha, div, tx_rdata, tx_empty, rx_full, miso,
    output busy, done, tx_rd, rx_wdata, rx_wr, sclk, mosi, scsn
  );

  modport slave (
    output work, op, len, cs_sel, cpol, cpha, div, tx_rdata, tx_empty, rx_full, miso,
    input  busy, done, tx_rd, rx_wdata, rx_wr, sclk, mosi, scsn
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master burst engine: pops TX words, shifts them MSB first in CPOL/CPHA mode, optionally pushes RX words.
// Latency: busy one cycle after work; each word 2*DATA*D SHIFT cycles plus FIFO pop/load/store overhead.
// Backpressure: stalls with SCLK idle and chip select held on TX empty, and on RX full when op=1.
// Ports: clk, rst (synchronous, active-high), bus (spi_master_ctrl_if.master: command, TX/RX FIFO and SPI pins).
module spi_master_ctrl #(
  parameter int DATA  = 8,
  parameter int NCS   = 2,
  parameter int DIV_W = 8,
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_ctrl_if.master bus
);
  localparam int CSW = (NCS > 1) ? $clog2(NCS) : 1;
  localparam int EW  = $clog2(2 * DATA);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FETCH, S_LOAD, S_SHIFT, S_STORE, S_HOLD
  } state_t;

  state_t           r_state;
  logic             r_op;
  logic             r_cpha;
  logic [LEN_W-1:0] r_len;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic [EW-1:0]    r_edge;
  logic             r_ld_wait;
  logic [DATA-1:0]  r_sh;
  logic [DATA-1:0]  r_rx;
  logic             r_busy;
  logic             r_done;
  logic             r_tx_rd;
  logic             r_rx_wr;
  logic [DATA-1:0]  r_rx_wdata;
  logic             r_sclk;
  logic             r_mosi;
  logic [NCS-1:0]   r_scsn;

  logic [NCS-1:0]   w_cs_dec;
  logic [DIV_W-1:0] w_div_eff;
  logic             w_cnt_end;
  logic             w_last_edge;
  logic             w_sample_edge;

  // An out-of-range index matches no line, so the burst runs with every select high.
  always_comb begin
    w_cs_dec = '1;
    for (int i = 0; i < NCS; i++) begin
      if (bus.cs_sel == CSW'(i)) w_cs_dec[i] = 1'b0;
    end
  end

  assign w_div_eff   = (bus.div == '0) ? DIV_W'(1) : bus.div;
  assign w_cnt_end   = (r_cnt == r_div - DIV_W'(1));
  assign w_last_edge = (r_edge == LAST_EDGE);
  // Even edges are leading; cpha=0 samples on leading, cpha=1 on trailing.
  assign w_sample_edge = (r_edge[0] == r_cpha);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= 1'b0;
      r_cpha     <= 1'b0;
      r_len      <= '0;
      r_div      <= DIV_W'(1);
      r_cnt      <= '0;
      r_edge     <= '0;
      r_ld_wait  <= 1'b0;
      r_sh       <= '0;
      r_rx       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tx_rd    <= 1'b0;
      r_rx_wr    <= 1'b0;
      r_rx_wdata <= '0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_scsn     <= '1;
    end else begin
      r_tx_rd <= 1'b0;
      r_rx_wr <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.work) begin
            r_op   <= bus.op;
            r_len  <= bus.len;
            r_cpha <= bus.cpha;
            r_div  <= w_div_eff;
            r_sclk <= bus.cpol;
            r_cnt  <= '0;
            if (bus.len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_busy  <= 1'b1;
              r_scsn  <= w_cs_dec;
              r_state <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (w_cnt_end) begin
            r_cnt   <= '0;
            r_state <= S_FETCH;
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end
        S_FETCH: begin
          if (!bus.tx_empty) begin
            r_tx_rd   <= 1'b1;
            r_ld_wait <= 1'b1;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          // First LOAD cycle is the pop cycle; FIFO data arrives one cycle later.
          if (r_ld_wait) begin
            r_ld_wait <= 1'b0;
          end else begin
            r_cnt  <= '0;
            r_edge <= '0;
            // For cpha=0 the MSB goes out now, so pre-shift it away; every drive edge
            // then simply emits the top bit of r_sh in both modes.
            if (!r_cpha) begin
              r_mosi <= bus.tx_rdata[DATA-1];
              r_sh   <= {bus.tx_rdata[DATA-2:0], 1'b0};
            end else begin
              r_sh <= bus.tx_rdata;
            end
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_cnt_end) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
            r_edge <= r_edge + EW'(1);
            if (w_sample_edge) begin
              r_rx <= {r_rx[DATA-2:0], bus.miso};
            end else if (!w_last_edge) begin
              r_mosi <= r_sh[DATA-1];
              r_sh   <= {r_sh[DATA-2:0], 1'b0};
            end
            // 2*DATA toggles leave sclk back at cpol.
            if (w_last_edge) r_state <= S_STORE;
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end
        S_STORE: begin
          if (!(r_op && bus.rx_full)) begin
            if (r_op) begin
              r_rx_wr    <= 1'b1;
              r_rx_wdata <= r_rx;
            end
            r_len <= r_len - LEN_W'(1);
            if (r_len == LEN_W'(1)) begin
              r_cnt   <= '0;
              r_state <= S_HOLD;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        S_HOLD: begin
          if (w_cnt_end) begin
            r_scsn  <= '1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.tx_rd    = r_tx_rd;
  assign bus.rx_wr    = r_rx_wr;
  assign bus.rx_wdata = r_rx_wdata;
  assign bus.sclk     = r_sclk;
  assign bus.mosi     = r_mosi;
  assign bus.scsn     = r_scsn;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: TX FIFO model, loopback or mode-3 slave on miso, negedge monitor.
// Ports: none; drives the interface slave side and the clk/rst pins of the engine.
module tb_spi_master_ctrl;
  logic clk;
  logic rst;

  spi_master_ctrl_if #(.DATA(8), .NCS(2), .DIV_W(8), .LEN_W(16)) bus ();

  spi_master_ctrl #(.DATA(8), .NCS(2), .DIV_W(8), .LEN_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // TX FIFO model: pop on tx_rd, data valid the following cycle; reset flushes it.
  logic [7:0] mem [0:31];
  logic [4:0] wp = '0;
  logic [4:0] rp = '0;
  assign bus.tx_empty = (wp == rp);
  always @(posedge clk) begin
    if (rst) rp <= wp;
    else if (bus.tx_rd) begin
      bus.tx_rdata <= mem[rp];
      rp <= rp + 5'd1;
    end
  end

  // miso source: loopback of mosi, or a mode-3 slave shifting out on falling sclk.
  logic       slv_mode = 1'b0;
  logic       slv_bit  = 1'b0;
  logic [7:0] slv_sh   = 8'h00;
  assign bus.miso = slv_mode ? slv_bit : bus.mosi;
  always @(negedge bus.sclk) begin
    if (slv_mode) begin
      slv_bit = slv_sh[7];
      slv_sh  = {slv_sh[6:0], 1'b0};
    end
  end

  // Monitor, sampled on the falling clk edge.
  int         cyc = 0, n_txrd = 0, n_rx = 0, n_done = 0, n_rise = 0, n_high = 0, n_csbad = 0;
  int         rise_t [0:255];
  logic [7:0] rxq [0:63];
  logic       sclk_prev = 1'b0;
  logic [1:0] exp_cs = 2'b11;
  always @(negedge clk) begin
    cyc++;
    if (bus.tx_rd) n_txrd++;
    if (bus.done) n_done++;
    if (bus.rx_wr) begin
      if (n_rx < 64) rxq[n_rx] = bus.rx_wdata;
      n_rx++;
    end
    if (bus.sclk && !sclk_prev) begin
      if (n_rise < 256) rise_t[n_rise] = cyc;
      n_rise++;
    end
    if (bus.sclk) n_high++;
    sclk_prev = bus.sclk;
    if (!rst && (bus.scsn !== (bus.busy ? exp_cs : 2'b11))) n_csbad++;
  end

  int n_chk = 0, n_err = 0;
  int b_txrd, b_rx, b_done, b_rise, b_high, b_csbad;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic snap();
    b_txrd = n_txrd; b_rx = n_rx; b_done = n_done;
    b_rise = n_rise; b_high = n_high; b_csbad = n_csbad;
  endtask

  task automatic push(input logic [7:0] v);
    mem[wp] = v;
    wp = wp + 5'd1;
  endtask

  task automatic start_burst(input logic o, input logic [15:0] l, input logic c,
                             input logic pol, input logic pha, input logic [7:0] d);
    bus.op = o; bus.len = l; bus.cs_sel = c; bus.cpol = pol; bus.cpha = pha; bus.div = d;
    bus.work = 1'b1;
    step();
    bus.work = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int b;
    b = n_done;
    for (int i = 0; i < maxc; i++) begin
      if (n_done != b) break;
      step();
    end
    chk(tag, 32'(n_done != b), 1);
  endtask

  task automatic wait_rises(input string tag, input int nr, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (n_rise - b_rise >= nr) break;
      step();
    end
    chk(tag, 32'(n_rise - b_rise >= nr), 1);
  endtask

  initial begin
    int toggles, csbad;
    logic sprev;
    rst = 1'b1;
    bus.work = 0; bus.op = 0; bus.len = 0; bus.cs_sel = 0; bus.cpol = 0; bus.cpha = 0;
    bus.div = 0; bus.tx_rdata = 0; bus.rx_full = 0;
    repeat (3) step();
    // reset state
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_tx_rd", bus.tx_rd, 0);
    chk("rst_rx_wr", bus.rx_wr, 0);
    chk("rst_rx_wdata", bus.rx_wdata, 0);
    chk("rst_sclk", bus.sclk, 0);
    chk("rst_mosi", bus.mosi, 0);
    chk("rst_scsn", bus.scsn, 2'b11);
    rst = 1'b0;
    step();

    // T1: mode 0, div=2, loopback, two words on cs 0
    snap(); exp_cs = 2'b10;
    push(8'hA5); push(8'h3C);
    start_burst(1, 16'd2, 0, 0, 0, 8'd2);
    chk("t1_busy_rise", bus.busy, 1);
    wait_done("t1_done_timeout", 300);
    repeat (3) step();
    chk("t1_rx_cnt", n_rx - b_rx, 2);
    chk("t1_rx0", rxq[b_rx], 8'hA5);
    chk("t1_rx1", rxq[b_rx + 1], 8'h3C);
    chk("t1_rises", n_rise - b_rise, 16);
    chk("t1_high_cyc", n_high - b_high, 32);
    chk("t1_rise_span", rise_t[b_rise + 7] - rise_t[b_rise], 28);
    chk("t1_txrd", n_txrd - b_txrd, 2);
    chk("t1_done_cnt", n_done - b_done, 1);
    chk("t1_cs", n_csbad - b_csbad, 0);

    // T2: mode 3, div=1, cs 1, slave returns 0x5A
    snap(); exp_cs = 2'b01;
    slv_sh = 8'h5A; slv_mode = 1'b1;
    push(8'h81);
    start_burst(1, 16'd1, 1, 1, 1, 8'd1);
    chk("t2_sclk_idle_busy", bus.sclk, 1);
    wait_done("t2_done_timeout", 200);
    repeat (3) step();
    chk("t2_rx_wdata", bus.rx_wdata, 8'h5A);
    chk("t2_rx_cnt", n_rx - b_rx, 1);
    chk("t2_sclk_idle_after", bus.sclk, 1);
    chk("t2_cs", n_csbad - b_csbad, 0);
    slv_mode = 1'b0;

    // T3: TX underrun, len=3 with one word queued
    snap(); exp_cs = 2'b10;
    push(8'h11);
    start_burst(1, 16'd3, 0, 0, 0, 8'd1);
    wait_rises("t3_word1_timeout", 8, 200);
    repeat (4) step();
    toggles = 0; csbad = 0; sprev = bus.sclk;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.sclk != sprev) toggles++;
      if (bus.scsn !== 2'b10) csbad++;
      sprev = bus.sclk;
    end
    chk("t3_stall_toggles", toggles, 0);
    chk("t3_stall_sclk", bus.sclk, 0);
    chk("t3_stall_cs", csbad, 0);
    chk("t3_stall_txrd", n_txrd - b_txrd, 1);
    push(8'h22); push(8'h33);
    wait_done("t3_done_timeout", 300);
    repeat (3) step();
    chk("t3_txrd", n_txrd - b_txrd, 3);
    chk("t3_done_cnt", n_done - b_done, 1);
    chk("t3_rx2", rxq[b_rx + 2], 8'h33);

    // T4a: RX full with op=1 holds word 2 back
    snap(); bus.rx_full = 1'b1;
    push(8'h96); push(8'h69);
    start_burst(1, 16'd2, 0, 0, 0, 8'd1);
    repeat (45) step();
    chk("t4_stall_rx", n_rx - b_rx, 0);
    chk("t4_stall_rises", n_rise - b_rise, 8);
    chk("t4_stall_txrd", n_txrd - b_txrd, 1);
    bus.rx_full = 1'b0;
    wait_done("t4_done_timeout", 200);
    repeat (3) step();
    chk("t4_rx_cnt", n_rx - b_rx, 2);
    chk("t4_rx0", rxq[b_rx], 8'h96);
    chk("t4_rx1", rxq[b_rx + 1], 8'h69);
    chk("t4_rises", n_rise - b_rise, 16);

    // T4b: op=0 ignores rx_full
    snap(); bus.rx_full = 1'b1;
    push(8'h0F); push(8'hF0);
    start_burst(0, 16'd2, 0, 0, 0, 8'd1);
    wait_done("t4b_done_timeout", 80);
    repeat (3) step();
    chk("t4b_rx_cnt", n_rx - b_rx, 0);
    chk("t4b_txrd", n_txrd - b_txrd, 2);
    bus.rx_full = 1'b0;

    // T5: len=0, then work while busy
    snap();
    start_burst(1, 16'd0, 0, 0, 0, 8'd2);
    chk("t5_len0_done", bus.done, 1);
    chk("t5_len0_busy", bus.busy, 0);
    chk("t5_len0_scsn", bus.scsn, 2'b11);
    step();
    chk("t5_len0_pulse", bus.done, 0);
    snap();
    push(8'h5C); push(8'hC5);
    start_burst(1, 16'd1, 0, 0, 0, 8'd2);
    repeat (5) step();
    start_burst(1, 16'd5, 0, 0, 0, 8'd2);
    wait_done("t5_done_timeout", 200);
    repeat (30) step();
    chk("t5_txrd", n_txrd - b_txrd, 1);
    chk("t5_done_cnt", n_done - b_done, 1);
    chk("t5_busy_end", bus.busy, 0);

    // T6: reset mid-SHIFT, then a clean burst
    rst = 1'b1; step(); rst = 1'b0; step();
    snap();
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    start_burst(1, 16'd4, 0, 0, 0, 8'd2);
    wait_rises("t6_shift_timeout", 2, 200);
    rst = 1'b1;
    step();
    chk("t6_rst_scsn", bus.scsn, 2'b11);
    chk("t6_rst_sclk", bus.sclk, 0);
    chk("t6_rst_busy", bus.busy, 0);
    rst = 1'b0;
    repeat (40) step();
    chk("t6_no_done", n_done - b_done, 0);
    chk("t6_no_txrd", n_txrd - b_txrd, 1);
    chk("t6_no_rx", n_rx - b_rx, 0);
    snap();
    push(8'hC3);
    start_burst(1, 16'd1, 0, 0, 0, 8'd2);
    wait_done("t6_done_timeout", 200);
    repeat (3) step();
    chk("t6_rx", rxq[b_rx], 8'hC3);
    chk("t6_done_cnt", n_done - b_done, 1);
    chk("t6_cs", n_csbad - b_csbad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Parametrised SPI master engine for the next-generation SPI path. It drains transmit words from a TX FIFO and shifts them out on a multi-chip-select SPI bus. When requested, it pushes received words into an RX FIFO. Compared with the current engine it adds runtime mode (CPOL/CPHA), a programmable SCLK divider, NCS chip selects, and stall-safe behaviour on TX underrun and RX overflow. It sits between the command FSM (len/op/work/busy) and the two buffer FIFOs, replacing the fixed SPI interface.

Parameters:
DATA, 8, word width in bits; shifted MSB first
NCS, 2, number of chip-select lines (>=1)
DIV_W, 8, width of the half-period divider input
LEN_W, 16, width of the word-count input

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
work  in  1  start pulse; accepted only when busy=0
op  in  1  0 = write-only (RX discarded), 1 = write/read (RX pushed)
len  in  LEN_W  words in burst
cs_sel  in  max(1,$clog2(NCS))  chip select index
cpol  in  1  SCLK idle level
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge
div  in  DIV_W  SCLK half-period in clk cycles; 0 treated as 1
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst end
tx_rdata  in  DATA  TX FIFO read data, valid the cycle after tx_rd
tx_rd  out  1  TX FIFO pop pulse
tx_empty  in  1  TX FIFO empty
rx_wdata  out  DATA  RX FIFO write data
rx_wr  out  1  RX FIFO push pulse
rx_full  in  1  RX FIFO full
sclk  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in
scsn  out  NCS  active-low chip selects

Behaviour:
- Reset values: busy=0, done=0, tx_rd=0, rx_wr=0, rx_wdata=0, sclk=0, mosi=0, scsn=all 1. Reset mid-burst aborts immediately: no done pulse, and no further FIFO access.
- Configuration latching: on work with busy=0, latch op, len, cs_sel, cpol, cpha and div. busy rises the next cycle. Changes to these inputs during a burst have no effect. work while busy=1 is ignored.
- sclk idles at the latched cpol from acceptance until return to IDLE, then holds that value. cs_sel >= NCS: no line asserted, but the burst still runs.
- FSM states: IDLE, SETUP, FETCH, LOAD, SHIFT, STORE, HOLD.
- IDLE: on work with len=0, done pulses 1 cycle after acceptance, scsn untouched and busy stays 0. On work with len>0, go to SETUP.
- SETUP: scsn[cs_sel]=0 and hold for D cycles (D = max(div,1)), then FETCH.
- FETCH: if tx_empty=1, stall with scsn held and sclk idle. Otherwise assert tx_rd for exactly 1 cycle, then LOAD.
- LOAD: capture tx_rdata into the shift register. For cpha=0, drive mosi=MSB. Go to SHIFT.
- SHIFT: 2*DATA SCLK edges, one every D clk cycles, so the word lasts 2*DATA*D cycles.
  - cpha=0: leading edges sample miso; trailing edges (except the last) drive the next bit.
  - cpha=1: leading edges drive the next bit (the first drives MSB); trailing edges sample.
  - After the last edge, sclk=cpol. Go to STORE.
- STORE: if op=1 and rx_full=1, stall. Otherwise, if op=1, pulse rx_wr for 1 cycle with rx_wdata = the received word. Decrement the remaining-word count. If remaining>0, go to FETCH (scsn stays low between words); else go to HOLD.
- HOLD: keep scsn low for D cycles, then deassert all scsn and pulse done for 1 cycle. busy falls in the same cycle; go to IDLE.
- op=0: rx_wr is never asserted and rx_full is ignored.
- The remaining-word counter is LEN_W wide. len=2^LEN_W-1 must complete without wrap.

Test Plan:
- cpol=0, cpha=0, div=2, len=2, TX 0xA5,0x3C, miso tied to mosi, op=1 -> scsn[0] low through the whole burst; 8 rising edges/word, each word 32 clk cycles; RX pushes 0xA5 then 0x3C; exactly 1 done pulse.
- cpol=1, cpha=1, div=1, len=1, TX 0x81, miso driven from slave model returning 0x5A, cs_sel=1 -> sclk idles high; scsn=2'b01 during burst; rx_wdata=0x5A.
- TX underrun: len=3 with only 1 word queued, second word written 20 cycles later -> after word 1, sclk stays idle and scsn low for 20+ cycles, then resumes; total 3 tx_rd pulses, 1 done.
- RX full, op=1, len=2: hold rx_full=1 for 10 cycles after word 1 -> no rx_wr and no word-2 SCLK edges until release; then 2 rx_wr pulses total. Same run with op=0 -> 0 rx_wr pulses, no stall.
- len=0 and work-while-busy: len=0 gives a done pulse 1 cycle after acceptance with scsn unchanged. A second work with len=5 during a len=1 burst is ignored (1 tx_rd pulse).
- Assert rst mid-SHIFT of a len=4 burst -> next cycle scsn=all 1, sclk=0, busy=0, no done pulse; a new burst then completes normally.
